zrb_uart_rx: RTL

- 8N1 UART receiver, the receive counterpart of zrb_uart_tx.
- Oversamples the serial input using an internal fractional-free tick divider, recovers one byte per frame and presents it with a single-cycle valid strobe.
- Flags framing errors.
- Sits between the board RX pin and the consuming logic. There is no backpressure: the consumer must capture data on the valid strobe.

---
 rtl/zrb_uart_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/zrb_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronized input, tick-divided oversampling, single mid-bit sample.
// Emits a one-clock valid strobe per good frame, or a frame_error strobe when the stop bit reads low.
module zrb_uart_rx #(
    parameter int unsigned INPUT_CLK  = 25000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned DIV   = (INPUT_CLK + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SMP_W = $clog2(OVERSAMPLE);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_s_q, rx_prev_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               fe_q, fe_d;
    logic               tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            div_q     <= '0;
            smp_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            div_q     <= div_d;
            smp_q     <= smp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        smp_d   = smp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        fe_d    = 1'b0;
        tick    = (div_q == DIV_W'(DIV - 1));

        // Divider and sample counter free-run while a frame is in progress; IDLE holds them at zero
        // so the first tick after the start edge lands exactly DIV clocks later.
        if (state_q != IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                smp_d = smp_q + SMP_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                div_d = '0;
                smp_d = '0;
                bit_d = '0;
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick && smp_q == SMP_W'(OVERSAMPLE / 2 - 1)) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        smp_d   = '0;
                    end
                end
            end
            DATA: begin
                if (tick && smp_q == '1) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && smp_q == '1) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = fe_q;
    assign busy        = (state_q != IDLE);

endmodule
